// File: rtl/hazard_scoreboard_if.sv
// ID-stage instruction fields in, forwarding-mux destination tags and stall out.
interface hazard_scoreboard_if #(
  parameter int RBITS = 4
);
  logic             id_valid;
  logic [RBITS-1:0] id_src1;
  logic [RBITS-1:0] id_src2;
  logic             id_use1;
  logic             id_use2;
  logic [RBITS-1:0] id_dest;
  logic             id_wren;
  logic             id_load;
  logic             id_mul;
  logic             stall;
  logic [RBITS-1:0] ex_dest;
  logic             ex_wren;
  logic [RBITS-1:0] mem_dest;
  logic             mem_wren;
  logic             mul_busy;

  modport master (
    output id_valid, id_src1, id_src2, id_use1, id_use2,
           id_dest, id_wren, id_load, id_mul,
    input  stall, ex_dest, ex_wren, mem_dest, mem_wren, mul_busy
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_use1, id_use2,
           id_dest, id_wren, id_load, id_mul,
    output stall, ex_dest, ex_wren, mem_dest, mem_wren, mul_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks EX/MEM destinations for operand forwarding and stalls ID on
// load-use hazards and while a multi-cycle multiply occupies EX.
module hazard_scoreboard #(
  parameter int RBITS   = 4,
  parameter int MUL_LAT = 3
) (
  input logic               clk,
  input logic               reset,
  hazard_scoreboard_if.slave bus
);
  localparam int MW = $clog2(MUL_LAT) + 1;

  typedef struct packed {
    logic [RBITS-1:0] dest;
    logic             wren;
    logic             load;
    logic             mul;
  } ex_slot_t;

  typedef struct packed {
    logic [RBITS-1:0] dest;
    logic             wren;
  } mem_slot_t;

  localparam ex_slot_t  EX_BUBBLE  = '0;
  localparam mem_slot_t MEM_BUBBLE = '0;

  ex_slot_t  ex_q,   ex_d;
  mem_slot_t mem_q,  mem_d;
  logic [MW-1:0] mcnt_q, mcnt_d;

  logic mul_busy;
  logic luh;
  logic stall;
  logic accept_mul;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ex_d   = ex_q;
    mem_d  = mem_q;
    mcnt_d = mcnt_q;

    // mcnt is only nonzero while the multiply still sits in EX
    mul_busy = ex_q.mul & (mcnt_q != '0);
    luh = ex_q.load & ex_q.wren & bus.id_valid &
          ((bus.id_use1 & (bus.id_src1 == ex_q.dest)) |
           (bus.id_use2 & (bus.id_src2 == ex_q.dest)));
    stall = bus.id_valid & (mul_busy | luh);

    // A load flagged as a multiply is treated purely as a load
    accept_mul = bus.id_valid & bus.id_mul & ~bus.id_load;

    if (mul_busy) begin
      mem_d  = MEM_BUBBLE;
      mcnt_d = mcnt_q - MW'(1);
    end else begin
      mem_d = '{dest: ex_q.dest, wren: ex_q.wren};
      if (stall || !bus.id_valid) begin
        ex_d = EX_BUBBLE;
      end else begin
        ex_d = '{dest: bus.id_dest, wren: bus.id_wren,
                 load: bus.id_load, mul: accept_mul};
        if (accept_mul) mcnt_d = MW'(MUL_LAT - 1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q   <= EX_BUBBLE;
      mem_q  <= MEM_BUBBLE;
      mcnt_q <= '0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign bus.stall    = stall;
  assign bus.mul_busy = mul_busy;
  assign bus.ex_dest  = ex_q.dest;
  assign bus.ex_wren  = ex_q.wren;
  assign bus.mem_dest = mem_q.dest;
  assign bus.mem_wren = mem_q.wren;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: each cycle drives one ID instruction, queues the expected
// outputs and compares them at the falling edge.
module tb_hazard_scoreboard;
  localparam int RBITS   = 4;
  localparam int MUL_LAT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.RBITS(RBITS)) bus ();

  hazard_scoreboard #(.RBITS(RBITS), .MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic             v;
    logic [RBITS-1:0] s1;
    logic [RBITS-1:0] s2;
    logic             u1;
    logic             u2;
    logic [RBITS-1:0] dest;
    logic             wr;
    logic             ld;
    logic             ml;
  } id_t;

  typedef struct packed {
    logic             stall;
    logic [RBITS-1:0] exd;
    logic             exw;
    logic [RBITS-1:0] memd;
    logic             memw;
    logic             busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  function automatic id_t nop();
    return '0;
  endfunction

  function automatic id_t alu(input logic [RBITS-1:0] d, s1, s2);
    return '{v:1'b1, s1:s1, s2:s2, u1:1'b1, u2:1'b1, dest:d, wr:1'b1, ld:1'b0, ml:1'b0};
  endfunction

  function automatic id_t ldr(input logic [RBITS-1:0] d, s1);
    return '{v:1'b1, s1:s1, s2:'0, u1:1'b1, u2:1'b0, dest:d, wr:1'b1, ld:1'b1, ml:1'b0};
  endfunction

  function automatic id_t mulop(input logic [RBITS-1:0] d);
    return '{v:1'b1, s1:4'd1, s2:4'd2, u1:1'b1, u2:1'b1, dest:d, wr:1'b1, ld:1'b0, ml:1'b1};
  endfunction

  task automatic drive(input id_t i);
    bus.id_valid = i.v;
    bus.id_src1  = i.s1;
    bus.id_src2  = i.s2;
    bus.id_use1  = i.u1;
    bus.id_use2  = i.u2;
    bus.id_dest  = i.dest;
    bus.id_wren  = i.wr;
    bus.id_load  = i.ld;
    bus.id_mul   = i.ml;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL c%0d %s: observed %0h expected %0h", cyc, tag, obs, expv);
    end
  endtask

  // One cycle: drive ID, queue the expectation, compare at negedge, advance.
  task automatic step(input id_t i, input logic st, input logic [RBITS-1:0] exd,
                      input logic exw, input logic [RBITS-1:0] memd,
                      input logic memw, input logic bsy);
    exp_t e;
    cyc++;
    drive(i);
    exp_q.push_back('{stall:st, exd:exd, exw:exw, memd:memd, memw:memw, busy:bsy});
    @(negedge clk);
    e = exp_q.pop_front();
    cmp("stall",    32'(bus.stall),    32'(e.stall));
    cmp("ex_dest",  32'(bus.ex_dest),  32'(e.exd));
    cmp("ex_wren",  32'(bus.ex_wren),  32'(e.exw));
    cmp("mem_dest", 32'(bus.mem_dest), 32'(e.memd));
    cmp("mem_wren", 32'(bus.mem_wren), 32'(e.memw));
    cmp("mul_busy", 32'(bus.mul_busy), 32'(e.busy));
    @(posedge clk);
    #1;
  endtask

  initial begin
    id_t t;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(id_t'({$urandom, $urandom}));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    //    instr                              st exd exw memd memw busy
    step(nop(),                             0, 0,  0,  0,   0,   0); // after reset
    // back-to-back ALU
    step(alu(3, 1, 2),                      0, 0,  0,  0,   0,   0);
    step(alu(4, 3, 3),                      0, 3,  1,  0,   0,   0);
    step(nop(),                             0, 4,  1,  3,   1,   0);
    step(nop(),                             0, 0,  0,  4,   1,   0);
    // load-use on src2
    step(ldr(5, 1),                         0, 0,  0,  0,   0,   0);
    t = alu(6, 2, 5); t.u1 = 1'b0;
    step(t,                                 1, 5,  1,  0,   0,   0);
    step(t,                                 0, 0,  0,  5,   1,   0);
    step(nop(),                             0, 6,  1,  0,   0,   0);
    // same register, src2 not used
    step(ldr(5, 1),                         0, 0,  0,  6,   1,   0);
    t = alu(6, 2, 5); t.u2 = 1'b0;
    step(t,                                 0, 5,  1,  0,   0,   0);
    // load without write enable never hazards
    t = ldr(9, 1); t.wr = 1'b0;
    step(t,                                 0, 6,  1,  5,   1,   0);
    step(alu(10, 9, 9),                     0, 9,  0,  6,   1,   0);
    step(nop(),                             0, 10, 1,  9,   0,   0);
    step(nop(),                             0, 0,  0,  10,  1,   0);
    // multiply occupancy with a continuous valid stream
    step(mulop(7),                          0, 0,  0,  0,   0,   0);
    step(alu(8, 1, 2),                      1, 7,  1,  0,   0,   1);
    step(alu(8, 1, 2),                      1, 7,  1,  0,   0,   1);
    step(alu(8, 7, 2),                      0, 7,  1,  0,   0,   0);
    step(nop(),                             0, 8,  1,  7,   1,   0);
    step(nop(),                             0, 0,  0,  8,   1,   0);
    // load and mul both set: behaves as a load
    t = ldr(11, 1); t.ml = 1'b1;
    step(t,                                 0, 0,  0,  0,   0,   0);
    step(alu(1, 11, 2),                     1, 11, 1,  0,   0,   0);
    step(nop(),                             0, 0,  0,  11,  1,   0);
    // idle ID with matching fields against a load in EX
    step(ldr(12, 1),                        0, 0,  0,  0,   0,   0);
    t = '{v:1'b0, s1:4'd12, s2:4'd12, u1:1'b1, u2:1'b1, dest:4'd12, wr:1'b1, ld:1'b1, ml:1'b1};
    step(t,                                 0, 12, 1,  0,   0,   0);
    step(nop(),                             0, 0,  0,  12,  1,   0);
    // reset on the first busy cycle
    step(mulop(13),                         0, 0,  0,  0,   0,   0);
    reset = 1'b1;
    step(alu(2, 1, 1),                      1, 13, 1,  0,   0,   1);
    reset = 1'b0;
    step(alu(14, 13, 13),                   0, 0,  0,  0,   0,   0);
    step(nop(),                             0, 14, 1,  0,   0,   0);
    // register 0 is compared like any other
    step(ldr(0, 1),                         0, 0,  0,  14,  1,   0);
    step(alu(15, 0, 3),                     1, 0,  1,  0,   0,   0);
    step(nop(),                             0, 0,  0,  0,   1,   0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
